// File: rtl/fir_pkg.sv
// Shared types, FSM encoding and default sizing for the time-multiplexed FIR engine.
package fir_pkg;

    localparam int DEFAULT_NTAPS = 16;
    localparam int PROD_W        = 24;

    typedef logic        [11:0] sample_t;
    typedef logic signed [11:0] coeff_t;
    typedef logic signed [23:0] prod_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Worst-case sum of ntaps full-scale products needs log2(ntaps) growth bits.
    function automatic int acc_width(input int ntaps);
        return PROD_W + $clog2(ntaps);
    endfunction

endpackage

// File: rtl/mult12x12.sv
// Combinational 12x12 multiplier: unsigned sample times signed coefficient, signed 24-bit product.
module mult12x12
    import fir_pkg::*;
(
    input  sample_t din,
    input  coeff_t  coeff,
    output prod_t   product
);

    logic signed [23:0] din_ext;
    logic signed [23:0] coeff_ext;

    // The exact product always fits in 24 signed bits, so the low half of a 24x24 multiply is exact.
    assign din_ext   = {12'd0, din};
    assign coeff_ext = {{12{coeff[11]}}, coeff};
    assign product   = din_ext * coeff_ext;

endmodule

// File: rtl/fir_mac_ctrl.sv
// FIR engine: circular delay line plus coefficient store feeding one shared multiplier, one tap per cycle.
// Optional output saturation is enabled by defining FIR_SAT_EN; otherwise the output wraps.
module fir_mac_ctrl
    import fir_pkg::*;
#(
    parameter int NTAPS = DEFAULT_NTAPS,
    parameter int SHIFT = 0,
    parameter int OUT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [11:0]              in_data,
    input  logic                     coeff_we,
    input  logic [$clog2(NTAPS)-1:0] coeff_addr,
    input  logic [11:0]              coeff_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     busy
);

    localparam int KW    = $clog2(NTAPS);
    localparam int ACC_W = acc_width(NTAPS);

    state_t                  state_reg;
    state_t                  state_next;
    logic [KW-1:0]           wr_ptr_reg;
    logic [KW-1:0]           k_reg;
    logic [KW-1:0]           rd_idx;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] scaled;
    logic [OUT_W-1:0]        out_data_reg;
    logic [OUT_W-1:0]        out_result;

    sample_t                 delay_reg [NTAPS];
    coeff_t                  coeff_reg [NTAPS];
    logic [NTAPS-1:0]        delay_wr_sel;
    logic [NTAPS-1:0]        coeff_wr_sel;

    logic                    accept;
    logic                    coeff_wr_ok;
    logic                    last_tap;
    sample_t                 tap_din;
    coeff_t                  tap_coeff;
    prod_t                   product;

    // Handshake outputs depend only on the registered state.
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == OUT);
    assign busy      = (state_reg != IDLE);
    assign out_data  = out_data_reg;

    assign accept      = in_valid && in_ready;
    assign coeff_wr_ok = coeff_we && (state_reg == IDLE);
    assign last_tap    = (k_reg == KW'(NTAPS - 1));

    // wr_ptr already points past the newest sample, so tap k sits at wr_ptr-1-k (mod NTAPS).
    assign rd_idx    = wr_ptr_reg - KW'(1) - k_reg;
    assign tap_din   = delay_reg[rd_idx];
    assign tap_coeff = coeff_reg[k_reg];

    mult12x12 u_mult (
        .din     (tap_din),
        .coeff   (tap_coeff),
        .product (product)
    );

    assign acc_sum = acc_reg + {{(ACC_W - PROD_W){product[PROD_W-1]}}, product};
    assign scaled  = acc_sum >>> SHIFT;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    always_comb begin
        out_result = scaled[OUT_W-1:0];
        if (scaled > SAT_MAX) begin
            out_result = SAT_MAX[OUT_W-1:0];
        end else if (scaled < SAT_MIN) begin
            out_result = SAT_MIN[OUT_W-1:0];
        end
    end
`else
    logic scaled_hi_unused;

    assign scaled_hi_unused = ^scaled[ACC_W-1:OUT_W];
    assign out_result       = scaled[OUT_W-1:0];
`endif

    // Per-entry write decodes for the register-array storage.
    for (genvar gi = 0; gi < NTAPS; gi++) begin : g_sel
        assign delay_wr_sel[gi] = accept && (wr_ptr_reg == KW'(gi));
        assign coeff_wr_sel[gi] = coeff_wr_ok && (coeff_addr == KW'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                delay_reg[i] <= '0;
                coeff_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NTAPS; i++) begin
                if (delay_wr_sel[i]) begin
                    delay_reg[i] <= in_data;
                end
                if (coeff_wr_sel[i]) begin
                    coeff_reg[i] <= coeff_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (accept)    state_next = MAC;
            MAC:     if (last_tap)  state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            k_reg        <= '0;
            acc_reg      <= '0;
            out_data_reg <= '0;
        end else begin
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + KW'(1);
                k_reg      <= '0;
                acc_reg    <= '0;
            end
            if (state_reg == MAC) begin
                acc_reg <= acc_sum;
                k_reg   <= k_reg + KW'(1);
                // The final tap is folded in on the way to the output register.
                if (last_tap) begin
                    out_data_reg <= out_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Directed bench for fir_mac_ctrl: table-driven sample vectors plus hand-written multi-cycle sequences.
module tb_fir_mac_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_data = '0;
    logic        coeff_we = 1'b0;
    logic [3:0]  coeff_addr = '0;
    logic [11:0] coeff_wdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        pre_rst;
        int          coeff_mode;   // 0 keep, 1 ramp k+1, 2 all -1, 3 all 2047
        logic [11:0] din;
        int          exp;
    } vec_t;

    vec_t vecs[33];

    fir_mac_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .coeff_we    (coeff_we),
        .coeff_addr  (coeff_addr),
        .coeff_wdata (coeff_wdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_coeff(input int addr, input int val);
        @(negedge clk);
        coeff_we    = 1'b1;
        coeff_addr  = 4'(addr);
        coeff_wdata = 12'(val);
        @(negedge clk);
        coeff_we    = 1'b0;
    endtask

    task automatic load_coeffs(input int mode);
        for (int k = 0; k < 16; k++) begin
            case (mode)
                1:       write_coeff(k, k + 1);
                2:       write_coeff(k, -1);
                3:       write_coeff(k, 2047);
                default: write_coeff(k, 1);
            endcase
        end
    endtask

    // wr_mode: 0 none, 1 coeff[0]=5 during MAC, 2 coeff[0]=3 in the accept cycle.
    task automatic do_sample(input logic [11:0] d, input int wr_mode, output int res, output int lat);
        int w;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        if (wr_mode == 2) begin
            coeff_we = 1'b1; coeff_addr = 4'd0; coeff_wdata = 12'd3;
        end
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        coeff_we = 1'b0;
        if (wr_mode == 1) begin
            coeff_we = 1'b1; coeff_addr = 4'd0; coeff_wdata = 12'd5;
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            coeff_we = 1'b0;
        end
        res = $signed(out_data);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int res;
        int lat;
        int w;

        for (int i = 0; i < 16; i++) begin
            vecs[i].pre_rst    = (i == 0);
            vecs[i].coeff_mode = (i == 0) ? 1 : 0;
            vecs[i].din        = (i == 0) ? 12'd100 : 12'd0;
            vecs[i].exp        = 100 * (i + 1);
        end
        for (int i = 16; i < 32; i++) begin
            vecs[i].pre_rst    = (i == 16);
            vecs[i].coeff_mode = (i == 16) ? 2 : 0;
            vecs[i].din        = 12'd10;
            vecs[i].exp        = -10 * (i - 15);
        end
        vecs[32].pre_rst    = 1'b1;
        vecs[32].coeff_mode = 3;
        vecs[32].din        = 12'd4095;
`ifdef FIR_SAT_EN
        vecs[32].exp        = 32767;
`else
        vecs[32].exp        = -6143;   // 16'hE801
`endif

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_data", int'(out_data), 0);
        chk("reset busy", int'(busy), 0);

        for (int i = 0; i < 33; i++) begin
            if (vecs[i].pre_rst) do_reset();
            if (vecs[i].coeff_mode != 0) load_coeffs(vecs[i].coeff_mode);
            do_sample(vecs[i].din, 0, res, lat);
            $display("vec %0d: din=%0d out=%0d exp=%0d lat=%0d", i, vecs[i].din, res, vecs[i].exp, lat);
            chk($sformatf("vec%0d out_data", i), res, vecs[i].exp);
            chk($sformatf("vec%0d latency", i), lat, 16);
        end

        // Backpressure: result held while out_ready is low, in_valid ignored.
        do_reset();
        write_coeff(0, 1);
        write_coeff(1, 1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 12'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 12'd55;
            chk($sformatf("bp%0d out_valid", c), int'(out_valid), 1);
            chk($sformatf("bp%0d out_data", c), $signed(out_data), 7);
            chk($sformatf("bp%0d in_ready", c), int'(in_ready), 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp release out_valid", int'(out_valid), 0);
        chk("bp release in_ready", int'(in_ready), 1);
        do_sample(12'd0, 0, res, lat);
        $display("backpressure follow-up: out=%0d exp=7", res);
        chk("bp follow-up out_data", res, 7);

        // Reset in the middle of a MAC pass.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 12'd50;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("midmac busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midmac rst in_ready", int'(in_ready), 1);
        chk("midmac rst out_valid", int'(out_valid), 0);
        chk("midmac rst busy", int'(busy), 0);
        load_coeffs(0);
        do_sample(12'd100, 0, res, lat);
        $display("post-reset sample: out=%0d exp=100", res);
        chk("midmac cleared out_data", res, 100);

        // Coefficient write while busy is dropped; write with accept lands.
        do_reset();
        write_coeff(0, 1);
        do_sample(12'd0, 1, res, lat);
        chk("busy-write first out_data", res, 0);
        do_sample(12'd1, 0, res, lat);
        $display("busy write: out=%0d exp=1", res);
        chk("busy-write dropped out_data", res, 1);
        do_sample(12'd2, 2, res, lat);
        $display("accept-cycle write: out=%0d exp=6", res);
        chk("accept-write used out_data", res, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
